// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci/Galois PRBS generator with multi-step advance,
// run-time seed load (zero-seed substitution), wrap detection and cycle counter.
module lfsr_prbs_gen #(
  parameter int unsigned    N          = 8,
  parameter logic [N-1:0]   TAPS       = 8'hB8,
  parameter logic [N-1:0]   RESET_SEED = '1,
  parameter int unsigned    STEP       = 1,
  parameter bit             GALOIS     = 1'b0,
  parameter int unsigned    CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     seed,
  output logic [N-1:0]     q,
  output logic [STEP-1:0]  bits_out,
  output logic             wrap,
  output logic             zero_seed,
  output logic [CNT_W-1:0] cyc_cnt
);

  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     start_q, start_d;
  logic [STEP-1:0]  bits_q, bits_d;
  logic             wrap_q, wrap_d;
  logic             zs_q, zs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     adv_s;
  logic [STEP-1:0]  adv_bits;
  logic             fb;

  // STEP sub-steps unrolled into one combinational chain.
  always_comb begin
    adv_s    = q_q;
    adv_bits = '0;
    fb       = 1'b0;
    for (int unsigned k = 0; k < STEP; k++) begin
      if (GALOIS) begin
        adv_bits[k] = adv_s[N-1];
        adv_s       = {adv_s[N-2:0], 1'b0} ^ ({N{adv_s[N-1]}} & TAPS);
      end else begin
        fb          = ^(adv_s & TAPS);
        adv_bits[k] = fb;
        adv_s       = {adv_s[N-2:0], fb};
      end
    end
  end

  always_comb begin
    q_d     = q_q;
    start_d = start_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    zs_d    = 1'b0;
    if (load) begin
      q_d     = (seed == '0) ? RESET_SEED : seed;
      start_d = (seed == '0) ? RESET_SEED : seed;
      bits_d  = '0;
      cnt_d   = '0;
      zs_d    = (seed == '0);
    end else if (en) begin
      q_d    = adv_s;
      bits_d = adv_bits;
      if (adv_s == start_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q != '1) begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= RESET_SEED;
      start_q <= RESET_SEED;
      bits_q  <= '0;
      wrap_q  <= 1'b0;
      zs_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      start_q <= start_d;
      bits_q  <= bits_d;
      wrap_q  <= wrap_d;
      zs_q    <= zs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q         = q_q;
  assign bits_out  = bits_q;
  assign wrap      = wrap_q;
  assign zero_seed = zs_q;
  assign cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench: four configurations driven in lockstep and compared
// against an arithmetic reference model of the PRBS rules.
module tb_lfsr_prbs_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;

  always #5 clk = ~clk;

  logic [7:0]  q0, q1, q2, q3;
  logic [0:0]  b0, b2;
  logic [1:0]  b1;
  logic [2:0]  b3;
  logic        w0, w1, w2, w3, z0, z1, z2, z3;
  logic [15:0] c0, c1, c2;
  logic [3:0]  c3;

  lfsr_prbs_gen #(.N(8)) u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .q(q0), .bits_out(b0), .wrap(w0), .zero_seed(z0), .cyc_cnt(c0));

  lfsr_prbs_gen #(.N(8), .STEP(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .q(q1), .bits_out(b1), .wrap(w1), .zero_seed(z1), .cyc_cnt(c1));

  lfsr_prbs_gen #(.N(8), .TAPS(8'h1D), .GALOIS(1'b1)) u_gal (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .q(q2), .bits_out(b2), .wrap(w2), .zero_seed(z2), .cyc_cnt(c2));

  lfsr_prbs_gen #(.N(8), .STEP(3), .CNT_W(4)) u_s3 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .q(q3), .bits_out(b3), .wrap(w3), .zero_seed(z3), .cyc_cnt(c3));

  logic [31:0] dq[4], db[4], dw[4], dz[4], dc[4];
  always_comb begin
    dq[0] = 32'(q0); dq[1] = 32'(q1); dq[2] = 32'(q2); dq[3] = 32'(q3);
    db[0] = 32'(b0); db[1] = 32'(b1); db[2] = 32'(b2); db[3] = 32'(b3);
    dw[0] = 32'(w0); dw[1] = 32'(w1); dw[2] = 32'(w2); dw[3] = 32'(w3);
    dz[0] = 32'(z0); dz[1] = 32'(z1); dz[2] = 32'(z2); dz[3] = 32'(z3);
    dc[0] = 32'(c0); dc[1] = 32'(c1); dc[2] = 32'(c2); dc[3] = 32'(c3);
  end

  int unsigned ctaps[4] = '{32'hB8, 32'hB8, 32'h1D, 32'hB8};
  int unsigned cstep[4] = '{1, 2, 1, 3};
  int unsigned cgal[4]  = '{0, 0, 1, 0};
  int unsigned cmax[4]  = '{65535, 65535, 65535, 15};

  int unsigned mq[4], mstart[4], mcnt[4], mbits[4], mwrap[4], mzs[4];

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned parity8(input int unsigned x);
    int unsigned p = 0;
    for (int i = 0; i < 8; i++) p = p ^ ((x >> i) & 1);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 255; mstart[i] = 255; mcnt[i] = 0;
      mbits[i] = 0; mwrap[i] = 0; mzs[i] = 0;
    end
  endtask

  task automatic model_step(input logic e, input logic l, input int unsigned sd);
    int unsigned s, bits, bit_e;
    for (int i = 0; i < 4; i++) begin
      if (l) begin
        mq[i] = (sd == 0) ? 255 : sd;
        mstart[i] = mq[i];
        mcnt[i] = 0; mbits[i] = 0; mwrap[i] = 0;
        mzs[i] = (sd == 0) ? 1 : 0;
      end else if (e) begin
        s = mq[i]; bits = 0;
        for (int k = 0; k < int'(cstep[i]); k++) begin
          if (cgal[i] != 0) begin
            bit_e = (s >> 7) & 1;
            s = ((s * 2) % 256) ^ ((bit_e != 0) ? ctaps[i] : 0);
          end else begin
            bit_e = parity8(s & ctaps[i]);
            s = ((s * 2) % 256) + bit_e;
          end
          bits = bits + (bit_e << k);
        end
        mq[i] = s; mbits[i] = bits; mzs[i] = 0;
        if (s == mstart[i]) begin
          mwrap[i] = 1; mcnt[i] = 0;
        end else begin
          mwrap[i] = 0;
          if (mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
        end
      end else begin
        mwrap[i] = 0; mzs[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q[%0d]", i),    dq[i], mq[i]);
      check($sformatf("bits[%0d]", i), db[i], mbits[i]);
      check($sformatf("wrap[%0d]", i), dw[i], mwrap[i]);
      check($sformatf("zs[%0d]", i),   dz[i], mzs[i]);
      check($sformatf("cnt[%0d]", i),  dc[i], mcnt[i]);
    end
  endtask

  task automatic do_cycle(input logic e, input logic l, input logic [7:0] sd);
    en = e; load = l; seed = sd;
    @(posedge clk);
    model_step(e, l, 32'(sd));
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] exp_q[5];
    logic       exp_b[5];
    bit         seen[256];
    int unsigned distinct;
    int unsigned r;
    logic [7:0]  rs;

    exp_q = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;

    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b1, 1'b0, 8'h00);
      seen[q0] = 1'b1;
      check("t1_q", 32'(q0), 32'(exp_q[k]));
      check("t1_bits", 32'(b0), 32'(exp_b[k]));
      if (k == 0) begin
        check("t3_q1", 32'(q1), 32'hFC);
        check("t3_bits1", 32'(b1), 32'h0);
      end
      if (k == 1) check("t3_q2", 32'(q1), 32'hF0);
    end

    for (int k = 5; k < 255; k++) begin
      do_cycle(1'b1, 1'b0, 8'h00);
      seen[q0] = 1'b1;
      check("t2_wrap", 32'(w0), (k == 254) ? 32'd1 : 32'd0);
      if (k == 253) check("t2_cnt254", 32'(c0), 32'd254);
      if (k == 254) begin
        check("t2_qwrap", 32'(q0), 32'hFF);
        check("t2_cnt0", 32'(c0), 32'd0);
      end
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("t2_distinct", distinct, 32'd255);

    do_cycle(1'b0, 1'b1, 8'h00);
    check("t4_q_zero", 32'(q0), 32'hFF);
    check("t4_zs", 32'(z0), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00);
    check("t4_zs_pulse", 32'(z0), 32'd0);
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    check("t4_b2b_zs", 32'(z0), 32'd1);
    do_cycle(1'b0, 1'b1, 8'h01);
    check("t4_q01", 32'(q0), 32'h01);
    check("t4_zs01", 32'(z0), 32'd0);

    do_cycle(1'b1, 1'b1, 8'h5A);
    check("t5_q", 32'(q0), 32'h5A);
    check("t5_cnt", 32'(c0), 32'd0);
    for (int k = 0; k < 255; k++) begin
      do_cycle(1'b1, 1'b0, 8'h00);
      if (k == 19) check("t5_sat", 32'(c3), 32'd15);
      if (k == 254) begin
        check("t5_wrap", 32'(w0), 32'd1);
        check("t5_qwrap", 32'(q0), 32'h5A);
      end
    end

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      rs = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      do_cycle(r < 80, r < 5, rs);
      if (k == 150) begin
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_q", 32'(q0), 32'hFF);
        check("t6_rst_cnt", 32'(c0), 32'd0);
        check_all();
        #1;
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
